// File: rtl/contador_regressivo_m_pkg.sv
// Shared types for the loadable modulo-M down-counter/timer.
package contador_regressivo_m_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    CONTANDO = 2'b01,
    PAUSADO  = 2'b10,
    FINAL    = 2'b11
  } estado_t;

endpackage

// File: rtl/contador_regressivo_m_if.sv
// Control/status bundle of the down-counter: loads and enables in, count and flags out.
interface contador_regressivo_m_if #(parameter int N = 16);
  logic         zera_s;
  logic         carrega;
  logic [N-1:0] valor;
  logic         conta;
  logic [N-1:0] Q;
  logic         fim;
  logic         meio;
  logic         zero;
  logic         ocupado;

  modport master (output zera_s, carrega, valor, conta,
                  input  Q, fim, meio, zero, ocupado);
  modport slave  (input  zera_s, carrega, valor, conta,
                  output Q, fim, meio, zero, ocupado);
endinterface

// File: rtl/contador_regressivo_m_divisor_tick.sv
// Prescaler: one tick every PRESC enabled cycles; limpa restarts the phase.
module divisor_tick #(
  parameter int PRESC = 1
) (
  input  logic clock,
  input  logic zera_as,
  input  logic limpa,
  input  logic habilita,
  output logic tick
);

  generate
    if (PRESC <= 1) begin : g_direto
      logic unused_ok;
      assign unused_ok = ^{clock, zera_as, limpa};
      assign tick      = habilita;
    end else begin : g_contador
      localparam int          W   = $clog2(PRESC);
      localparam logic [W-1:0] ULT = W'(PRESC - 1);
      logic [W-1:0] cnt_q;

      always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as)       cnt_q <= '0;
        else if (limpa)    cnt_q <= '0;
        else if (habilita) cnt_q <= (cnt_q == ULT) ? '0 : cnt_q + 1'b1;
      end

      assign tick = habilita && (cnt_q == ULT);
    end
  endgenerate

endmodule

// File: rtl/contador_regressivo_m.sv
// Loadable modulo-M down-counter/timer with pause, midpoint/end flags and optional auto-reload.
module contador_regressivo_m
  import contador_regressivo_m_pkg::*;
#(
  parameter int M     = 24000,
  parameter int N     = 16,
  parameter int PRESC = 1,
  parameter bit AUTO  = 1'b0
) (
  input  logic                    clock,
  input  logic                    zera_as,
  contador_regressivo_m_if.slave  io
);

  localparam logic [N-1:0] MAX  = N'(M - 1);
  localparam logic [N-1:0] UM   = N'(1);
  localparam logic [N-1:0] DOIS = N'(2);

  estado_t      st_q, st_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] carga_q, carga_d;
  logic [N-1:0] sat;
  logic         habilita, limpa, tick;

  assign sat = (io.valor > MAX) ? MAX : io.valor;

  // Prescaler only advances in a live, enabled countdown; any load, clear or end restarts its phase.
  assign habilita = (st_q == CONTANDO) && io.conta && !io.zera_s && !io.carrega;
  assign limpa    = io.zera_s || io.carrega || (st_q == FINAL);

  divisor_tick #(.PRESC(PRESC)) u_div (
    .clock    (clock),
    .zera_as  (zera_as),
    .limpa    (limpa),
    .habilita (habilita),
    .tick     (tick)
  );

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      st_q    <= OCIOSO;
      q_q     <= '0;
      carga_q <= '0;
    end else begin
      st_q    <= st_d;
      q_q     <= q_d;
      carga_q <= carga_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    q_d     = q_q;
    carga_d = carga_q;
    if (io.zera_s) begin
      st_d    = OCIOSO;
      q_d     = '0;
      carga_d = '0;
    end else if (io.carrega) begin
      carga_d = sat;
      q_d     = sat;
      st_d    = (sat == '0) ? FINAL : CONTANDO;
    end else begin
      unique case (st_q)
        OCIOSO: ;
        CONTANDO: begin
          if (!io.conta) begin
            st_d = PAUSADO;
          end else if (tick) begin
            if (q_q <= UM) begin
              q_d  = '0;
              st_d = FINAL;
            end else begin
              q_d = q_q - UM;
            end
          end
        end
        PAUSADO: if (io.conta) st_d = CONTANDO;
        FINAL: begin
          // A zero carga would re-enter FINAL every other cycle; park in OCIOSO instead.
          if (AUTO && (carga_q != '0)) begin
            q_d  = carga_q;
            st_d = CONTANDO;
          end else begin
            q_d  = '0;
            st_d = OCIOSO;
          end
        end
        default: st_d = OCIOSO;
      endcase
    end
  end

  assign io.Q       = q_q;
  assign io.fim     = (st_q == FINAL);
  assign io.ocupado = (st_q == CONTANDO) || (st_q == PAUSADO);
  assign io.zero    = (q_q == '0);
  assign io.meio    = io.ocupado && (carga_q >= DOIS) && (q_q == (carga_q >> 1));

endmodule

// File: tb/tb_contador_regressivo_m.sv
// Directed bench for contador_regressivo_m: basic, prescaled/paused and auto-reload instances.
module tb_contador_regressivo_m;

  logic clk = 1'b0;
  logic rst;
  int   nerr = 0;
  int   nchk = 0;

  always #5 clk = ~clk;

  contador_regressivo_m_if #(.N(4)) ia ();
  contador_regressivo_m_if #(.N(4)) ib ();
  contador_regressivo_m_if #(.N(4)) ic ();

  contador_regressivo_m #(.M(10), .N(4), .PRESC(1), .AUTO(1'b0)) dut_a (.clock(clk), .zera_as(rst), .io(ia));
  contador_regressivo_m #(.M(10), .N(4), .PRESC(3), .AUTO(1'b0)) dut_b (.clock(clk), .zera_as(rst), .io(ib));
  contador_regressivo_m #(.M(10), .N(4), .PRESC(1), .AUTO(1'b1)) dut_c (.clock(clk), .zera_as(rst), .io(ic));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    {ia.zera_s, ia.carrega, ia.conta, ia.valor} = '0;
    {ib.zera_s, ib.carrega, ib.conta, ib.valor} = '0;
    {ic.zera_s, ic.carrega, ic.conta, ic.valor} = '0;
    rst = 1'b1;
    step(); step();
    chk("rst_Q", ia.Q, 0);
    chk("rst_zero", ia.zero, 1);
    chk("rst_ocupado", ia.ocupado, 0);
    chk("rst_fim", ia.fim, 0);
    chk("rst_meio", ia.meio, 0);
    rst = 1'b0;
    step();

    // Basic countdown from 5
    ia.valor = 4'd5; ia.carrega = 1'b1; ia.conta = 1'b1;
    step();
    ia.carrega = 1'b0;
    chk("basic_Q5", ia.Q, 5);
    chk("basic_ocupado", ia.ocupado, 1);
    chk("basic_meio5", ia.meio, 0);
    for (int e = 4; e >= 1; e--) begin
      step();
      chk("basic_Q", ia.Q, e);
      chk("basic_meio", ia.meio, (e == 2) ? 1 : 0);
      chk("basic_fim_low", ia.fim, 0);
    end
    step();
    chk("basic_fim", ia.fim, 1);
    chk("basic_Q0", ia.Q, 0);
    chk("basic_zero", ia.zero, 1);
    chk("basic_fim_ocupado", ia.ocupado, 0);
    step();
    chk("basic_fim_once", ia.fim, 0);
    chk("basic_idle_Q", ia.Q, 0);
    chk("basic_idle_ocupado", ia.ocupado, 0);

    // Saturation, then zero load
    ia.valor = 4'd15; ia.carrega = 1'b1; ia.conta = 1'b0;
    step();
    chk("sat_Q9", ia.Q, 9);
    ia.valor = 4'd0;
    step();
    ia.carrega = 1'b0;
    chk("zero_load_fim", ia.fim, 1);
    chk("zero_load_ocupado", ia.ocupado, 0);
    chk("zero_load_Q", ia.Q, 0);
    step();
    chk("zero_load_fim_off", ia.fim, 0);
    chk("zero_load_ocupado2", ia.ocupado, 0);

    // Retrigger at Q=2
    ia.valor = 4'd5; ia.carrega = 1'b1; ia.conta = 1'b1;
    step();
    ia.carrega = 1'b0;
    step(); step(); step();
    chk("retrig_Q2", ia.Q, 2);
    ia.valor = 4'd7; ia.carrega = 1'b1;
    step();
    ia.carrega = 1'b0;
    chk("retrig_Q7", ia.Q, 7);
    chk("retrig_nofim", ia.fim, 0);
    step();
    chk("retrig_Q6", ia.Q, 6);

    // carrega together with zera_s: clear wins
    ia.valor = 4'd3; ia.carrega = 1'b1; ia.zera_s = 1'b1;
    step();
    ia.carrega = 1'b0; ia.zera_s = 1'b0;
    chk("clr_prio_Q", ia.Q, 0);
    chk("clr_prio_ocupado", ia.ocupado, 0);

    // Asynchronous reset between edges at Q=3
    ia.valor = 4'd5; ia.carrega = 1'b1; ia.conta = 1'b1;
    step();
    ia.carrega = 1'b0;
    step(); step();
    chk("async_pre_Q3", ia.Q, 3);
    #2 rst = 1'b1;
    #1;
    chk("async_Q", ia.Q, 0);
    chk("async_ocupado", ia.ocupado, 0);
    chk("async_zero", ia.zero, 1);
    chk("async_fim", ia.fim, 0);
    #1 rst = 1'b0;
    ia.valor = 4'd2; ia.carrega = 1'b1;
    step();
    ia.carrega = 1'b0;
    chk("async_reload_Q2", ia.Q, 2);
    step();
    chk("async_reload_Q1", ia.Q, 1);
    step();
    chk("async_reload_fim", ia.fim, 1);
    ia.conta = 1'b0;

    // PRESC=3: load 4, 5 enabled cycles, 7-cycle pause, resume edge, 7 more enabled cycles
    ib.valor = 4'd4; ib.carrega = 1'b1; ib.conta = 1'b1;
    step();
    ib.carrega = 1'b0;
    chk("presc_Q4", ib.Q, 4);
    repeat (5) step();
    chk("presc_Q3", ib.Q, 3);
    ib.conta = 1'b0;
    repeat (7) step();
    chk("pause_Q3", ib.Q, 3);
    chk("pause_ocupado", ib.ocupado, 1);
    ib.conta = 1'b1;
    step();
    chk("resume_Q3", ib.Q, 3);
    step();
    chk("resume_tick_Q2", ib.Q, 2);
    repeat (5) step();
    chk("presc_Q1", ib.Q, 1);
    chk("presc_fim_low", ib.fim, 0);
    step();
    chk("presc_fim", ib.fim, 1);
    chk("presc_Q0", ib.Q, 0);
    ib.conta = 1'b0;

    // Auto-reload: load 3, five periods of 4 cycles
    ic.valor = 4'd3; ic.carrega = 1'b1; ic.conta = 1'b1;
    step();
    ic.carrega = 1'b0;
    chk("auto_Q3", ic.Q, 3);
    for (int p = 0; p < 5; p++) begin
      step(); chk("auto_Q2", ic.Q, 2); chk("auto_meio", ic.meio, 0);
      step(); chk("auto_Q1", ic.Q, 1); chk("auto_meio1", ic.meio, 1);
      step(); chk("auto_fim", ic.fim, 1); chk("auto_Q0", ic.Q, 0);
      step(); chk("auto_reload", ic.Q, 3); chk("auto_fim_off", ic.fim, 0);
    end
    ic.zera_s = 1'b1;
    step();
    ic.zera_s = 1'b0;
    chk("auto_clr_Q", ic.Q, 0);
    chk("auto_clr_ocupado", ic.ocupado, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("auto_clr_nofim", ic.fim, 0);
    end

    // carrega in the FINAL cycle overrides auto-reload
    ic.valor = 4'd2; ic.carrega = 1'b1;
    step();
    ic.carrega = 1'b0;
    step();
    chk("final_load_Q1", ic.Q, 1);
    step();
    chk("final_load_fim", ic.fim, 1);
    ic.valor = 4'd6; ic.carrega = 1'b1;
    step();
    ic.carrega = 1'b0;
    chk("final_load_Q6", ic.Q, 6);
    chk("final_load_ocupado", ic.ocupado, 1);
    step();
    chk("final_load_Q5", ic.Q, 5);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
